// File: rtl/sobel_stream_if.sv
// Pixel stream bundle for sobel_stream: the input beat side and the result beat side.
// No backpressure: valid-only on both sides; slave is the filter, master the pixel source/sink.
interface sobel_stream_if #(
    parameter int WORD_SIZE = 8
);
    logic                 in_valid;
    logic                 in_sof;
    logic [WORD_SIZE-1:0] inputPixel;
    logic                 out_valid;
    logic                 out_sof;
    logic [WORD_SIZE-1:0] outputPixel;

    modport master (
        output in_valid, in_sof, inputPixel,
        input  out_valid, out_sof, outputPixel
    );

    modport slave (
        input  in_valid, in_sof, inputPixel,
        output out_valid, out_sof, outputPixel
    );
endinterface

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector with runtime row length, zeroed borders and four output modes.
// Latency 2 cycles per beat; no backpressure, input bubbles pass through one-for-one.
module sobel_stream #(
    parameter int WORD_SIZE    = 8,
    parameter int MAX_ROW_SIZE = 1024,
    parameter int CW           = $clog2(MAX_ROW_SIZE + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [CW-1:0]        rowSize,
    input  logic [1:0]           mode,
    input  logic [WORD_SIZE+2:0] threshold,
    sobel_stream_if.slave        px
);
    localparam int AW = (MAX_ROW_SIZE > 1) ? $clog2(MAX_ROW_SIZE) : 1;
    localparam int GW = WORD_SIZE + 2;
    localparam int SW = WORD_SIZE + 3;
    localparam int RW = 16;

    typedef logic [WORD_SIZE-1:0] pix_t;

    function automatic logic [GW-1:0] wsum(input pix_t a, input pix_t b, input pix_t c);
        return GW'(a) + (GW'(b) << 1) + GW'(c);
    endfunction

    function automatic logic [GW-1:0] absdiff(input logic [GW-1:0] a, input logic [GW-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Frame position and line storage
    logic [CW-1:0] row_len;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    pix_t          lb0 [MAX_ROW_SIZE];
    pix_t          lb1 [MAX_ROW_SIZE];

    // Stage 1
    pix_t          win [3][3];
    logic          s1_valid;
    logic          s1_sof;
    logic          s1_border;
    logic [GW-1:0] s1_gx;
    logic [GW-1:0] s1_gy;

    // Stage 2
    logic          out_valid_q;
    logic          out_sof_q;
    pix_t          out_pix_q;

    logic          beat;
    logic          sof_beat;
    logic          wrap;
    logic          border;
    logic [CW-1:0] sof_len;
    logic [CW-1:0] cur_len;
    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;
    logic [AW-1:0] addr;
    pix_t          lb0_rd;
    pix_t          lb1_rd;
    pix_t          win_nxt [3][3];
    logic [GW-1:0] l_sum, r_sum, t_sum, b_sum;
    logic [GW-1:0] gx_nxt, gy_nxt;
    logic [SW-1:0] sum;
    pix_t          result;

    // An sof beat is itself position (0,0) with the freshly latched length.
    always_comb begin
        sof_len = rowSize;
        if (rowSize < CW'(3)) begin
            sof_len = CW'(3);
        end else if (rowSize > CW'(MAX_ROW_SIZE)) begin
            sof_len = CW'(MAX_ROW_SIZE);
        end
        beat     = px.in_valid;
        sof_beat = px.in_valid & px.in_sof;
        cur_len  = sof_beat ? sof_len : row_len;
        cur_col  = sof_beat ? '0 : col;
        cur_row  = sof_beat ? '0 : row;
        wrap     = (cur_col == cur_len - CW'(1));
        border   = (cur_row < RW'(2)) || (cur_col < CW'(2));
        addr     = cur_col[AW-1:0];
    end

    assign lb0_rd = lb0[addr];
    assign lb1_rd = lb1[addr];

    always_ff @(posedge clock) begin
        if (beat) begin
            lb1[addr] <= lb0_rd;
            lb0[addr] <= px.inputPixel;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            row_len <= CW'(3);
            col     <= '0;
            row     <= '0;
        end else if (beat) begin
            row_len <= cur_len;
            if (wrap) begin
                col <= '0;
                row <= (cur_row != '1) ? cur_row + RW'(1) : cur_row;
            end else begin
                col <= cur_col + CW'(1);
                row <= cur_row;
            end
        end
    end

    // Column 0 is the newest; rows 1 and 2 come from the line buffers before they are overwritten.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_nxt[r][2] = win[r][1];
            win_nxt[r][1] = win[r][0];
        end
        win_nxt[0][0] = px.inputPixel;
        win_nxt[1][0] = lb0_rd;
        win_nxt[2][0] = lb1_rd;

        l_sum  = wsum(win_nxt[0][0], win_nxt[1][0], win_nxt[2][0]);
        r_sum  = wsum(win_nxt[0][2], win_nxt[1][2], win_nxt[2][2]);
        t_sum  = wsum(win_nxt[0][0], win_nxt[0][1], win_nxt[0][2]);
        b_sum  = wsum(win_nxt[2][0], win_nxt[2][1], win_nxt[2][2]);
        gx_nxt = absdiff(l_sum, r_sum);
        gy_nxt = absdiff(t_sum, b_sum);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_sof    <= 1'b0;
            s1_border <= 1'b0;
            s1_gx     <= '0;
            s1_gy     <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else begin
            s1_valid <= beat;
            if (beat) begin
                win       <= win_nxt;
                s1_sof    <= px.in_sof;
                s1_border <= border;
                s1_gx     <= gx_nxt;
                s1_gy     <= gy_nxt;
            end
        end
    end

    // Mode and threshold are taken live here, at the stage that registers the result.
    always_comb begin
        sum = SW'(s1_gx) + SW'(s1_gy);
        case (mode)
            2'd0:    result = sum[SW-1] ? '1 : sum[GW-1:2];
            2'd1:    result = (sum >= threshold) ? '1 : '0;
            2'd2:    result = s1_gx[GW-1:2];
            default: result = s1_gy[GW-1:2];
        endcase
        if (s1_border) begin
            result = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_pix_q   <= '0;
        end else begin
            out_valid_q <= s1_valid;
            out_sof_q   <= s1_valid & s1_sof;
            out_pix_q   <= s1_valid ? result : '0;
        end
    end

    assign px.out_valid   = out_valid_q;
    assign px.out_sof     = out_sof_q;
    assign px.outputPixel = out_pix_q;
endmodule

// File: tb/tb_sobel_stream.sv
// Directed vector bench for sobel_stream: table of small frames plus restart and reset sequences.
module tb_sobel_stream;
    typedef logic [15:0][7:0] img_t;

    typedef struct {
        logic [10:0] rsz;
        int          len;
        int          npix;
        logic [1:0]  mode;
        logic [10:0] thr;
        bit          bub;
        img_t        img;
        img_t        exp;
        string       name;
    } vec_t;

    logic        clock;
    logic        reset;
    logic [10:0] rowSize;
    logic [1:0]  mode;
    logic [10:0] threshold;

    sobel_stream_if #(.WORD_SIZE(8)) px ();

    sobel_stream #(.WORD_SIZE(8), .MAX_ROW_SIZE(1024)) dut (
        .clock     (clock),
        .reset     (reset),
        .rowSize   (rowSize),
        .mode      (mode),
        .threshold (threshold),
        .px        (px)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int nvec = 0;
    int nerr = 0;

    logic [7:0] exp_pix_q[$];
    bit         exp_sof_q[$];
    int         in_cyc_q[$];
    logic [7:0] out_pix_q[$];
    logic       out_sof_q[$];
    int         out_cyc_q[$];

    always @(negedge clock) begin
        if (px.out_valid === 1'b1) begin
            out_pix_q.push_back(px.outputPixel);
            out_sof_q.push_back(px.out_sof);
            out_cyc_q.push_back(cyc);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic clear_q();
        exp_pix_q.delete();
        exp_sof_q.delete();
        in_cyc_q.delete();
        out_pix_q.delete();
        out_sof_q.delete();
        out_cyc_q.delete();
    endtask

    task automatic send_beat(input bit sof, input logic [7:0] pix, input logic [7:0] e);
        @(negedge clock);
        px.in_valid   = 1'b1;
        px.in_sof     = sof;
        px.inputPixel = pix;
        in_cyc_q.push_back(cyc);
        exp_pix_q.push_back(e);
        exp_sof_q.push_back(sof);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            px.in_valid = 1'b0;
            px.in_sof   = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        chk($sformatf("%s count", tag), out_pix_q.size(), exp_pix_q.size());
        n = (out_pix_q.size() < exp_pix_q.size()) ? out_pix_q.size() : exp_pix_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s[%0d] pix", tag, i), out_pix_q[i], exp_pix_q[i]);
            chk($sformatf("%s[%0d] sof", tag, i), out_sof_q[i], exp_sof_q[i]);
            chk($sformatf("%s[%0d] lat", tag, i), out_cyc_q[i] - in_cyc_q[i], 2);
        end
    endtask

    // Pixel index = r*len + c.
    function automatic img_t mk_img(input int kind, input int len);
        img_t m = '0;
        for (int i = 0; i < 16; i++) begin
            int r = i / len;
            int c = i % len;
            case (kind)
                0:       m[i] = 8'd100;
                1:       m[i] = (c >= 2) ? 8'd255 : 8'd0;
                2:       m[i] = (r >= 2) ? 8'd255 : 8'd0;
                default: m[i] = (r >= 2 && c >= 2) ? 8'd255 : 8'd0;
            endcase
        end
        return m;
    endfunction

    // 4x4 frame: only (2,2),(2,3),(3,2),(3,3) lie outside the border.
    function automatic img_t exp4(input logic [7:0] a, input logic [7:0] b,
                                  input logic [7:0] c, input logic [7:0] d);
        img_t e = '0;
        e[10] = a;
        e[11] = b;
        e[14] = c;
        e[15] = d;
        return e;
    endfunction

    function automatic vec_t mkv(input string name, input int rsz, input int len, input int npix,
                                 input int md, input int thr, input bit bub,
                                 input int kind, input img_t e);
        vec_t v;
        v.name = name;
        v.rsz  = 11'(rsz);
        v.len  = len;
        v.npix = npix;
        v.mode = 2'(md);
        v.thr  = 11'(thr);
        v.bub  = bub;
        v.img  = mk_img(kind, len);
        v.exp  = e;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        clear_q();
        rowSize   = v.rsz;
        mode      = v.mode;
        threshold = v.thr;
        for (int i = 0; i < v.npix; i++) begin
            send_beat(i == 0, v.img[i], v.exp[i]);
            if (v.bub) idle(2);
        end
        idle(4);
        check_all(v.name);
    endtask

    vec_t vecs[16];
    img_t clamp_exp;
    img_t vedge_img;
    img_t vedge_exp;

    initial begin
        clamp_exp    = '0;
        clamp_exp[8] = 8'd255;
        vedge_img    = mk_img(1, 4);
        vedge_exp    = exp4(255, 255, 255, 255);

        //             name        rsz len np md  thr  bub kind expected
        vecs[0]  = mkv("flat_m0",   4, 4, 16, 0,    0, 0, 0, exp4(0, 0, 0, 0));
        vecs[1]  = mkv("flat_m1t0", 4, 4, 16, 1,    0, 0, 0, exp4(255, 255, 255, 255));
        vecs[2]  = mkv("vedge_m0",  4, 4, 16, 0,    0, 0, 1, exp4(255, 255, 255, 255));
        vecs[3]  = mkv("vedge_m3",  4, 4, 16, 3,    0, 0, 1, exp4(0, 0, 0, 0));
        vecs[4]  = mkv("vedge_m2",  4, 4, 16, 2,    0, 0, 1, exp4(255, 255, 255, 255));
        vecs[5]  = mkv("vedge_t1020", 4, 4, 16, 1, 1020, 0, 1, exp4(255, 255, 255, 255));
        vecs[6]  = mkv("vedge_t1021", 4, 4, 16, 1, 1021, 0, 1, exp4(0, 0, 0, 0));
        vecs[7]  = mkv("vedge_bub", 4, 4, 16, 0,    0, 1, 1, exp4(255, 255, 255, 255));
        vecs[8]  = mkv("hedge_m2",  4, 4, 16, 2,    0, 0, 2, exp4(0, 0, 0, 0));
        vecs[9]  = mkv("hedge_m3",  4, 4, 16, 3,    0, 0, 2, exp4(255, 255, 255, 255));
        vecs[10] = mkv("quad_m0",   4, 4, 16, 0,    0, 0, 3, exp4(127, 255, 255, 255));
        vecs[11] = mkv("quad_m2",   4, 4, 16, 2,    0, 0, 3, exp4(63, 63, 191, 191));
        vecs[12] = mkv("quad_m3",   4, 4, 16, 3,    0, 0, 3, exp4(63, 191, 63, 191));
        vecs[13] = mkv("quad_t1021", 4, 4, 16, 1, 1021, 0, 3, exp4(0, 0, 0, 255));
        vecs[14] = mkv("quad_t510b", 4, 4, 16, 1,  510, 1, 3, exp4(255, 255, 255, 255));
        vecs[15] = mkv("clamp_rs2", 2, 3,  9, 0,    0, 0, 1, clamp_exp);

        reset         = 1'b1;
        rowSize       = 11'd4;
        mode          = 2'd0;
        threshold     = 11'd0;
        px.in_valid   = 1'b0;
        px.in_sof     = 1'b0;
        px.inputPixel = 8'd0;
        repeat (3) @(negedge clock);
        chk("reset out_valid", px.out_valid, 0);
        chk("reset out_sof", px.out_sof, 0);
        chk("reset outputPixel", px.outputPixel, 0);
        reset = 1'b0;
        idle(2);

        for (int v = 0; v < 16; v++) begin
            run_vec(vecs[v]);
        end

        // Restart mid-row: 9 beats of a 6-wide frame, then a fresh 4-wide frame back to back.
        clear_q();
        rowSize = 11'd6;
        mode    = 2'd0;
        for (int i = 0; i < 9; i++) begin
            send_beat(i == 0, 8'(37 * i + 5), 8'd0);
        end
        rowSize = 11'd4;
        for (int i = 0; i < 16; i++) begin
            send_beat(i == 0, vedge_img[i], vedge_exp[i]);
        end
        idle(4);
        check_all("restart");

        // Reset during row 3, then non-sof beats (default 3-wide frame), then a normal frame.
        clear_q();
        rowSize = 11'd4;
        mode    = 2'd0;
        for (int i = 0; i < 14; i++) begin
            send_beat(i == 0, vedge_img[i], vedge_exp[i]);
        end
        @(negedge clock);
        px.in_valid = 1'b0;
        px.in_sof   = 1'b0;
        reset       = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midreset out_valid", px.out_valid, 0);
        chk("midreset outputPixel", px.outputPixel, 0);
        chk("midreset out_sof", px.out_sof, 0);
        @(negedge clock);
        chk("midreset drain out_valid", px.out_valid, 0);
        clear_q();
        rowSize = 11'd6;
        begin
            img_t m = mk_img(1, 3);
            for (int i = 0; i < 9; i++) begin
                send_beat(1'b0, m[i], clamp_exp[i]);
            end
        end
        idle(4);
        check_all("postreset_nosof");
        run_vec(vecs[10]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/sobel_stream.md
# sobel_stream

Streaming 3x3 Sobel edge detector: the parametrised successor of the fixed-row Sobel block. Adds a runtime row length up to `MAX_ROW_SIZE`, a valid/start-of-frame stream interface tolerating input bubbles, explicit zeroed border handling, and four output modes. It sits in the pixel pipeline between the frame source and downstream thresholding and storage stages.

## Interface

- `WORD_SIZE`, 8, pixel width in bits.
- `MAX_ROW_SIZE`, 1024, maximum pixels per row; sets the depth of each line buffer.
- `CW`, derived, `$clog2(MAX_ROW_SIZE+1)`, width of `rowSize`.

Reset is synchronous and active-high on `reset`; one clock, `clock`.

- `clock`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rowSize`  in  CW  pixels per row; sampled only on a beat with `in_sof`=1.
- `mode`  in  2  0=magnitude, 1=binary threshold, 2=horizontal gradient only, 3=vertical gradient only.
- `threshold`  in  WORD_SIZE+3  compare level for mode 1.
- `in_valid`  in  1  `inputPixel` is valid this cycle.
- `in_sof`  in  1  first pixel of a frame; qualified by `in_valid`.
- `inputPixel`  in  WORD_SIZE  raster-order pixel.
- `out_valid`  out  1  `outputPixel` is valid.
- `out_sof`  out  1  output beat that corresponds to the input `in_sof` beat.
- `outputPixel`  out  WORD_SIZE  result pixel.

## Operation

- **Beats.** An accepted beat is one where `in_valid`=1. There is no backpressure. Cycles with `in_valid`=0 change no state except draining the output pipeline.
- **Row length.** On an `in_sof` beat, the latched row length L = max(`rowSize`, 3), also clamped to `MAX_ROW_SIZE`. The row counter r and column counter c are forced so that this beat is (0,0). An `in_sof` beat mid-frame restarts the frame immediately.
- **Counters.** c increments per beat and wraps from L-1 to 0. r increments on each wrap and saturates at all-ones.
- **Line buffers.** Two line buffers, each MAX_ROW_SIZE x WORD_SIZE, addressed by c, read-before-write.
  - Per beat: LB1[c] <= LB0[c] and LB0[c] <= inputPixel.
  - The old LB0[c] and LB1[c] form rows 1 and 2 of the newest window column.
- **Window.** W[row][col] is 3x3. Row 0 is the current row and row 2 the oldest. Col 0 is the newest column, and it shifts one column per beat.
- **Gradients.** Sums are WORD_SIZE+2 bits, unsigned.
  - L = W00+2W10+W20, R = W02+2W12+W22, gx = |L−R|.
  - T = W00+2W01+W02, B = W20+2W21+W22, gy = |T−B|.
- **Output value.** sum = gx+gy, WORD_SIZE+3 bits.
  - Mode 0: sum[W+2] ? all-ones : sum[W+1:2].
  - Mode 1: (sum >= `threshold`) ? all-ones : 0.
  - Mode 2: gx[W+1:2].
  - Mode 3: gy[W+1:2].
- **Border.** When the beat's r<2 or c<2, `outputPixel`=0 regardless of mode. Buffer contents from a previous frame never reach the output.
- **Output count.** Exactly one output beat is produced per input beat, in order.
- **Mode changes.** `mode` and `threshold` are sampled in stage 2, the same cycle the result is registered. Changing them mid-frame affects only beats that have not yet reached stage 2.

## Timing

- Stage 1 (registered): window shift, gx, gy, border flag, sof tag.
- Stage 2 (registered): mode select, saturation or threshold, producing `outputPixel`, `out_valid` and `out_sof`.
- Latency: an input beat at cycle N produces `out_valid`=1 at cycle N+2. Bubbles propagate 1:1.
- Reset values: `out_valid`=0, `out_sof`=0, `outputPixel`=0, pipeline valids 0, r=c=0, L=3, window registers 0.
  - Line-buffer RAM is not reset; the border rule masks it.
- Reset mid-frame: the cycle after `reset` is asserted, `out_valid`=0. In-flight beats are discarded.
  - Each frame must start with an `in_sof` beat. A non-sof beat after reset is processed as if r=c=0 and L=3.
- Simultaneous `in_sof` and column wrap: `in_sof` wins, so (0,0).

## Test plan

- **Flat frame:** L=4, 4 rows, all pixels 100, mode 0 → 16 outputs, all 0. `out_sof` only on output 0. Latency is 2 cycles.
- **Vertical edge:** L=4, every row 0,0,255,255, mode 0 → rows 0–1 all 0. Rows 2–3 give 0,0,255,255 (gx=1020, gy=0).
  - Same image in mode 3 → all 0. In mode 2 → 255 at c=2,3.
- **Threshold:** same image, mode 1, `threshold`=1020 → 255 at (r≥2, c=2,3). With `threshold`=1021 → all 0.
- **Bubbles:** repeat the vertical-edge test with `in_valid` toggling 1,0,0,1,… → an identical output sequence. `out_valid` follows the input gaps shifted by 2.
- **Mid-frame restart:** L=6, after 9 beats assert `in_sof` with `rowSize`=4 → the next 8 outputs are 0 (border). The frame then matches a fresh L=4 run.
- **Reset mid-frame:** pulse `reset` during row 3 → the next cycle `out_valid`=0 and `outputPixel`=0. The next frame after `in_sof` matches the reference model exactly.
